// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared constants for counter_modal and the blocks that drive it.
//   dir_e          : counting direction carried on the 'up' control line
//   MODE_WRAP      : Saturate parameter value selecting wrap-around at limits
//   MODE_SATURATE  : Saturate parameter value selecting hold-at-limit
//   params_legal() : elaboration-time parameter sanity check
// -----------------------------------------------------------------------------
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;

  // True when the width/limit/reset-value combination is usable: at least one
  // bit, a non-zero limit that fits in the width, and a reset value in range.
  function automatic bit params_legal(int size, int max, int reset_value);
    longint full_scale;
    full_scale = (longint'(1) << size) - 1;
    return (size >= 1) && (size <= 31) && (max >= 1) &&
           (longint'(max) <= full_scale) &&
           (reset_value >= 0) && (reset_value <= max);
  endfunction

endpackage : counter_pkg

// File: rtl/counter_modal_if.sv
// -----------------------------------------------------------------------------
// counter_modal_if
// Command/status bundle for counter_modal.
//   Commands (master -> slave): enable, up, load, load_value, clear,
//                               overflow_clear
//   Status   (slave -> master): count, at_max, at_zero, wrapped, overflow
// Size must match the Size parameter of the counter attached to the slave
// modport.
// -----------------------------------------------------------------------------
interface counter_modal_if #(
  parameter int Size = 5
);

  logic            enable;
  logic            up;
  logic            load;
  logic [Size-1:0] load_value;
  logic            clear;
  logic            overflow_clear;

  logic [Size-1:0] count;
  logic            at_max;
  logic            at_zero;
  logic            wrapped;
  logic            overflow;

  modport master (
    output enable, up, load, load_value, clear, overflow_clear,
    input  count, at_max, at_zero, wrapped, overflow
  );

  modport slave (
    input  enable, up, load, load_value, clear, overflow_clear,
    output count, at_max, at_zero, wrapped, overflow
  );

endinterface : counter_modal_if

// File: rtl/counter_modal.sv
// -----------------------------------------------------------------------------
// counter_modal
// Modulo-(Max+1) up/down counter with synchronous clear/load, count enable,
// wrap-or-saturate behaviour at the limits, a one-cycle limit pulse and a
// sticky overflow flag.
//
// Parameters
//   Size       : counter width in bits
//   Max        : highest count value; range is 0..Max
//   Saturate   : MODE_WRAP wraps at the limits, MODE_SATURATE holds there
//   ResetValue : count after reset and after clear
//
// Ports
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : counter_modal_if.slave
//           in : enable, up, load, load_value, clear, overflow_clear
//           out: count, at_max, at_zero (decoded from count),
//                wrapped (registered pulse), overflow (sticky)
//
// Per edge the command priority is clear > load > enable. overflow_clear acts
// on every edge that is not a clear, and loses to a limit event on the same
// edge.
// -----------------------------------------------------------------------------
module counter_modal
  import counter_pkg::*;
#(
  parameter int Size       = 5,
  parameter int Max        = (2 ** Size) - 1,
  parameter int Saturate   = MODE_WRAP,
  parameter int ResetValue = 0
) (
  input logic            clock,
  input logic            reset,
  counter_modal_if.slave bus
);

  // Refuse to elaborate with parameters that cannot describe a valid range.
  if (!params_legal(Size, Max, ResetValue)) begin : g_bad_params
    $error("counter_modal: illegal parameters Size=%0d Max=%0d ResetValue=%0d",
           Size, Max, ResetValue);
  end

  // Limit arithmetic runs one bit wider than the count so that count+1 at
  // Max and count-1 at zero are visible as real excursions, never aliased.
  localparam logic [Size:0]   MaxExt   = Max[Size:0];
  localparam logic [Size:0]   OneExt   = {{Size{1'b0}}, 1'b1};
  localparam logic [Size-1:0] MaxVal   = Max[Size-1:0];
  localparam logic [Size-1:0] ResetVal = ResetValue[Size-1:0];
  localparam bit              SatMode  = (Saturate == MODE_SATURATE);

  logic [Size-1:0] count_q, count_d;
  logic            wrapped_q, wrapped_d;
  logic            overflow_q, overflow_d;

  logic [Size:0] count_ext;
  logic [Size:0] load_ext;
  logic [Size:0] inc_ext;
  logic [Size:0] dec_ext;
  logic          inc_past_max;
  logic          dec_past_zero;
  logic          limit_hit;

  assign count_ext     = {1'b0, count_q};
  assign load_ext      = {1'b0, bus.load_value};
  assign inc_ext       = count_ext + OneExt;
  assign dec_ext       = count_ext - OneExt;
  assign inc_past_max  = (inc_ext > MaxExt);
  // Decrementing zero borrows into the extra bit.
  assign dec_past_zero = dec_ext[Size];

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    count_d    = count_q;
    wrapped_d  = 1'b0;
    overflow_d = overflow_q;
    limit_hit  = 1'b0;

    if (bus.clear) begin
      count_d    = ResetVal;
      overflow_d = 1'b0;
    end else begin
      if (bus.load) begin
        // Out-of-range load values clamp to the top of the range.
        count_d = (load_ext > MaxExt) ? MaxVal : bus.load_value;
      end else if (bus.enable) begin
        if (dir_e'(bus.up) == DIR_UP) begin
          if (inc_past_max) begin
            limit_hit = 1'b1;
            count_d   = SatMode ? MaxVal : '0;
          end else begin
            count_d = inc_ext[Size-1:0];
          end
        end else begin
          if (dec_past_zero) begin
            limit_hit = 1'b1;
            count_d   = SatMode ? '0 : MaxVal;
          end else begin
            count_d = dec_ext[Size-1:0];
          end
        end
      end

      wrapped_d = limit_hit;
      // A limit event on the same edge beats a request to clear the flag.
      overflow_d = limit_hit | (overflow_q & ~bus.overflow_clear);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q    <= ResetVal;
      wrapped_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrapped_q  <= wrapped_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.wrapped  = wrapped_q;
  assign bus.overflow = overflow_q;
  assign bus.at_max   = (count_q == MaxVal);
  assign bus.at_zero  = (count_q == '0);

endmodule : counter_modal
